// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ==== mem_arb_pkg : shared types and constants for mem_arbiter -- rev 1.0 ====
package mem_arb_pkg;
  localparam int DATA_W         = 32;
  localparam int MAX_STREAK_DEF = 4;
  localparam int STREAK_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/arb_streak_cnt.sv
`default_nettype none
// ==== arb_streak_cnt : saturating count of data grants taken while fetch waits -- rev 1.0 ====
module arb_streak_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic max_hit
);
  localparam logic [STREAK_W-1:0] MAX_VAL = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count < MAX_VAL)) begin
      count <= count + STREAK_W'(1);
    end
  end

  assign max_hit = (count == MAX_VAL);
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ==== mem_arbiter : single-port memory arbiter, data priority with fetch anti-starvation -- rev 1.0 ====
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              stall_f,
  output logic              stall_m
);
  state_t state;
  logic   decide;
  logic   grant_d;
  logic   grant_i;
  logic   max_hit;
  logic   streak_inc;
  logic   streak_clr;

  // A completing transfer doubles as a decision point so the next grant has no bubble.
  assign decide  = (state == IDLE) || m_ready;
  assign grant_d = decide && d_req && !(if_req && max_hit);
  assign grant_i = decide && if_req && !grant_d;

  assign streak_inc = grant_d && if_req;
  assign streak_clr = decide && (grant_i || !if_req);

  arb_streak_cnt #(
    .MAX_STREAK (MAX_STREAK)
  ) u_streak (
    .clk     (clk),
    .reset   (reset),
    .inc     (streak_inc),
    .clr     (streak_clr),
    .max_hit (max_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (decide) begin
      if (grant_d) begin
        state   <= BUSY_D;
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        state   <= BUSY_I;
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
      end else begin
        state   <= IDLE;
        m_req   <= 1'b0;
        m_we    <= 1'b0;
        m_addr  <= '0;
        m_wdata <= '0;
      end
    end
  end

  assign if_ready = m_ready && (state == BUSY_I);
  assign d_ready  = m_ready && (state == BUSY_D);
  assign if_rdata = if_ready ? m_rdata : '0;
  assign d_rdata  = d_ready  ? m_rdata : '0;
  assign stall_f  = if_req && !if_ready;
  assign stall_m  = d_req && !d_ready;
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4: max consecutive data grants while fetch waits; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch request, held until if_ready.
REQ-005 if_addr  in  32  fetch address (PC), stable while if_req.
REQ-006 if_rdata  out  32  fetched instruction, valid when if_ready.
REQ-007 if_ready  out  1  one-cycle fetch completion pulse.
REQ-008 d_req  in  1  data-stage request, held until d_ready.
REQ-009 d_we  in  1  1 = store, 0 = load; stable while d_req.
REQ-010 d_addr  in  32  data address (ALU result), stable while d_req.
REQ-011 d_wdata  in  32  store data, stable while d_req.
REQ-012 d_rdata  out  32  load data, valid when d_ready.
REQ-013 d_ready  out  1  one-cycle data completion pulse.
REQ-014 m_req  out  1  memory request, registered.
REQ-015 m_we  out  1  memory write enable, registered.
REQ-016 m_addr  out  32  memory address, registered.
REQ-017 m_wdata  out  32  memory write data, registered.
REQ-018 m_rdata  in  32  memory read data, valid when m_ready.
REQ-019 m_ready  in  1  memory completion pulse; arbitrary latency of at least 1 cycle after m_req rises.
REQ-020 stall_f  out  1  fetch stall = if_req && !if_ready.
REQ-021 stall_m  out  1  data-stage stall = d_req && !d_ready.

Function
REQ-022 FSM states: IDLE, BUSY_I, BUSY_D.
- Transaction: m_req, m_we, m_addr and m_wdata are loaded on the grant edge and held constant until the edge on which m_ready is sampled high.
REQ-023 Grant decision is taken in IDLE, or in BUSY_x on the m_ready cycle, so back-to-back transfers have no idle bubble.
REQ-024 Priority: data wins, unless if_req is high and streak == MAX_STREAK; then fetch wins.
REQ-025 Streak counter:
- increments on each data grant while if_req is high;
- clears on a fetch grant, or when if_req is low at the decision point;
- saturates at MAX_STREAK.
REQ-026 Latency: request first seen on edge N -> m_req high from cycle N+1 -> ready asserted combinationally in the same cycle as m_ready (minimum 2 cycles).
REQ-027 Completion routing:
- if_ready = m_ready && state==BUSY_I; d_ready = m_ready && state==BUSY_D.
- rdata outputs pass m_rdata through; they are 0 when the matching ready is low.
- m_ready in IDLE is ignored.
REQ-028 Fetch grants force m_we = 0 and m_wdata = 0.
REQ-029 If a requester drops req mid-transaction, the memory transaction still completes; the ready pulse is still emitted and may be ignored.
REQ-030 The m_ready cycle with no pending requests -> IDLE, with m_req low on the next cycle.

Reset
REQ-031 While reset is low, outputs take these values immediately and asynchronously:
- state = IDLE;
- streak = 0;
- m_req, m_we, m_addr, m_wdata = 0.
REQ-032 A reset asserted mid-transaction abandons the transaction; no ready pulse is issued; a late m_ready after release is ignored in IDLE.
REQ-033 The first grant after release occurs no earlier than the first rising edge with reset high.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY_I/BUSY_D), the MAX_STREAK default, and the 32-bit width constant.
REQ-035 Sub-module arb_streak_cnt SHALL implement the saturating streak counter (inc, clr, max_hit); all other logic stays in mem_arbiter.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x00000010, m_ready pulses 3 cycles after m_req with m_rdata=0x00500113 -> m_addr=0x10, m_we=0, if_ready=1 for exactly 1 cycle, if_rdata=0x00500113.
REQ-037 Simultaneous requests: d_req store (addr 0x100, wdata 0xDEADBEEF) and if_req raised on the same edge -> data granted first (m_we=1), then fetch granted on the m_ready cycle with no idle cycle; stall_f high throughout.
REQ-038 Starvation with MAX_STREAK=4: d_req held continuously with new addresses, if_req held -> 4 data grants, then 1 fetch grant, then data resumes.
REQ-039 Mid-transaction reset: reset low 2 cycles into BUSY_D -> m_req=0 immediately; no d_ready; m_ready pulsed after release is ignored; state IDLE.
REQ-040 Dropped request: if_req falls before m_ready -> m_req stays high until m_ready; the if_ready pulse still occurs; next state IDLE.
REQ-041 Idle spurious m_ready=1 with no requests -> if_ready=d_ready=0, rdata outputs 0, no state change.
